// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store; LS has priority.
// Optional `ARB_TIMEOUT_EN aborts a hung access after TIMEOUT busy cycles and flags bus_err.
module mem_port_arbiter #(
  parameter int ADDRESS = 32,
  parameter int DATA    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDRESS-1:0]  if_addr,
  output logic                if_valid,
  output logic [DATA-1:0]     if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDRESS-1:0]  ls_addr,
  input  logic [DATA-1:0]     ls_wdata,
  input  logic [DATA/8-1:0]   ls_be,
  output logic                dm_valid,
  output logic [DATA-1:0]     dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDRESS-1:0]  mem_addr,
  output logic [DATA-1:0]     mem_wdata,
  output logic [DATA/8-1:0]   mem_be,
  input  logic [DATA-1:0]     mem_rdata,
  input  logic                mem_ack,
  output logic                bus_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] LS_BUSY = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0] state_reg;
  logic       busy;
  logic       timeout_hit;

  assign busy = (state_reg == IF_BUSY) || (state_reg == LS_BUSY);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_reg;

  // Counter sits at zero in IDLE, so every BUSY entry starts from a clean count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (!busy) begin
      count_reg <= '0;
    end else if (!mem_ack) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign timeout_hit = busy && !mem_ack && (count_reg == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ls_req) begin
            state_reg <= LS_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_be    <= ls_be;
          end else if (if_req) begin
            state_reg <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[ADDRESS-1:2], 2'b00};
            mem_wdata <= '0;
            mem_be    <= '1;
          end
        end
        IF_BUSY, LS_BUSY: begin
          // An ack in the same cycle as the timeout takes precedence.
          if (mem_ack || timeout_hit) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            bus_err   <= !mem_ack;
            if (state_reg == IF_BUSY) begin
              if_valid <= 1'b1;
              if (mem_ack) if_rdata <= mem_rdata;
            end else begin
              dm_valid <= 1'b1;
              if (mem_ack && !mem_we) dm_rdata <= mem_rdata;
            end
          end
        end
        // Requests are deliberately not sampled here so a requester can drop req after valid.
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder logs accesses, a monitor
// pops expected responses on every valid pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS(32), .DATA(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          is_ls;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } acc_t;

  resp_t exp_q[$];
  acc_t  acc_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int valid_cnt = 0;
  int if_cyc = 0;
  int dm_cyc = 0;

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (if_valid && dm_valid) check("one_valid_only", 32'(if_valid & dm_valid), 32'd0);
      if (!if_valid && !dm_valid && bus_err) check("stray_bus_err", 32'(bus_err), 32'd0);
      if (if_valid || dm_valid) begin
        valid_cnt++;
        if (if_valid) if_cyc = cyc;
        else dm_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(if_valid | dm_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("resp %s rdata=0x%08h bus_err=%0b at cycle %0d",
                   dm_valid ? "LS" : "IF", dm_valid ? dm_rdata : if_rdata, bus_err, cyc);
          check("resp_port", 32'(dm_valid), 32'(e.is_ls));
          check("resp_bus_err", 32'(bus_err), 32'(e.err));
          if (e.is_ls) check("dm_rdata", dm_rdata, e.rdata);
          else check("if_rdata", if_rdata, e.rdata);
        end
      end
    end
  end

  int ack_wait = 0;
  bit no_ack = 1'b0;
  int last_busy = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h104) ? 32'h0000_0093 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: acks after ack_wait extra cycles, checks fields stay stable while waiting
  initial begin
    int   cnt;
    acc_t a;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt == 0) begin
          a.addr = mem_addr; a.we = mem_we; a.wdata = mem_wdata; a.be = mem_be;
          acc_q.push_back(a);
        end else begin
          check("stable_addr", mem_addr, a.addr);
          check("stable_wdata", mem_wdata, a.wdata);
          check("stable_ctl", {27'd0, mem_we, mem_be}, {27'd0, a.we, a.be});
        end
        if (!no_ack && cnt == ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
        end
        cnt++;
      end else begin
        if (cnt != 0) last_busy = cnt;
        cnt = 0;
      end
    end
  end

  task automatic wait_valid(input bit ls, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(ls ? dm_valid : if_valid) && n < budget);
    check(ls ? "dm_valid_seen" : "if_valid_seen", 32'(ls ? dm_valid : if_valid), 32'd1);
    // Requester drops its request only after the RESP cycle has ended.
    @(posedge clk); #1;
    if (ls) ls_req = 1'b0;
    else if_req = 1'b0;
  endtask

  task automatic expect_acc(input string tag, input logic [31:0] addr, input bit we,
                            input logic [31:0] wdata, input logic [3:0] be);
    acc_t a;
    if (acc_q.size() == 0) begin
      check({tag, "_missing"}, 32'(acc_q.size()), 32'd1);
    end else begin
      a = acc_q.pop_front();
      $display("access %s addr=0x%08h we=%0b wdata=0x%08h be=0x%h", tag, a.addr, a.we, a.wdata, a.be);
      check({tag, "_addr"}, a.addr, addr);
      check({tag, "_ctl"}, {27'd0, a.we, a.be}, {27'd0, we, be});
      if (we) check({tag, "_wdata"}, a.wdata, wdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({mem_req, mem_we, mem_be, if_valid, dm_valid, bus_err}), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
  endtask

  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;
  int          req_cyc;
  int          v0;
  int          n;

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fetch, misaligned PC
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0106; req_cyc = cyc;
    exp_q.push_back('{1'b0, 32'h0000_0093, 1'b0}); last_if = 32'h0000_0093;
    wait_valid(1'b0, 10);
    check("if_latency", if_cyc - req_cyc, 32'd2);
    expect_acc("fetch", 32'h104, 1'b0, 32'd0, 4'hF);

    // Simultaneous requests: LS first, IF next
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_010C;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; ls_be = 4'hF;
    exp_q.push_back('{1'b1, mem_val(32'h200), 1'b0}); last_dm = mem_val(32'h200);
    exp_q.push_back('{1'b0, mem_val(32'h10C), 1'b0}); last_if = mem_val(32'h10C);
    wait_valid(1'b1, 10);
    wait_valid(1'b0, 10);
    check("if_after_ls_gap", if_cyc - dm_cyc, 32'd3);
    expect_acc("prio_ls", 32'h200, 1'b0, 32'd0, 4'hF);
    expect_acc("prio_if", 32'h10C, 1'b0, 32'd0, 4'hF);

    // Store with wait states; dm_rdata must keep the previous load value
    @(negedge clk);
    ack_wait = 4;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'h3;
    exp_q.push_back('{1'b1, last_dm, 1'b0});
    wait_valid(1'b1, 20);
    check("store_busy_cycles", last_busy, 32'd5);
    expect_acc("store", 32'h40, 1'b1, 32'hDEAD_BEEF, 4'h3);
    ack_wait = 0;

    // Fetch held through RESP: exactly one access
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0300;
    exp_q.push_back('{1'b0, mem_val(32'h300), 1'b0}); last_if = mem_val(32'h300);
    wait_valid(1'b0, 10);
    repeat (5) @(negedge clk);
    expect_acc("noregrant", 32'h300, 1'b0, 32'd0, 4'hF);
    check("noregrant_count", acc_q.size(), 32'd0);

    // Fetch with two wait states, low address bits set
    @(negedge clk);
    ack_wait = 2;
    if_req = 1'b1; if_addr = 32'h0000_2003; req_cyc = cyc;
    exp_q.push_back('{1'b0, mem_val(32'h2000), 1'b0}); last_if = mem_val(32'h2000);
    wait_valid(1'b0, 20);
    check("if_wait_latency", if_cyc - req_cyc, 32'd4);
    expect_acc("fetch_wait", 32'h2000, 1'b0, 32'd0, 4'hF);
    ack_wait = 0;

    // Asynchronous reset in the middle of a store
    @(negedge clk);
    no_ack = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'h1234_5678; ls_be = 4'hF;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!mem_req && n < 10);
    check("midrst_req_up", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check_all_zero("midrst");
    ls_req = 1'b0; no_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v0 = valid_cnt;
    repeat (6) @(negedge clk);
    check("no_valid_after_rst", valid_cnt, v0);
    acc_q.delete();
    last_if = '0; last_dm = '0;

    // Recovery after reset
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; ls_be = 4'hF;
    exp_q.push_back('{1'b1, mem_val(32'h500), 1'b0}); last_dm = mem_val(32'h500);
    wait_valid(1'b1, 10);
    expect_acc("recover", 32'h500, 1'b0, 32'd0, 4'hF);

`ifdef ARB_TIMEOUT_EN
    // Hung fetch is aborted after 16 busy cycles; if_rdata keeps its old value
    @(negedge clk);
    no_ack = 1'b1;
    if_req = 1'b1; if_addr = 32'h600;
    exp_q.push_back('{1'b0, last_if, 1'b1});
    wait_valid(1'b0, 40);
    check("timeout_busy_cycles", last_busy, 32'd16);
    expect_acc("timeout", 32'h600, 1'b0, 32'd0, 4'hF);
    no_ack = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("accesses_drained", acc_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and the load/store unit (LS) of the RV32I core.
- Sequences each access with a small FSM and returns responses as one-cycle pulses.
- dm_valid feeds the PC stall term (load && ~DM_valid).
- LS has fixed priority over IF, so the in-flight instruction retires before the next fetch.

Parameters:
ADDRESS, 32, address width
DATA, 32, data width
TIMEOUT, 16, cycles before a hung access is aborted (used only with the optional feature)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request; held high until if_valid
if_addr  input  ADDRESS  fetch address (pc address_out)
if_valid  output  1  one-cycle pulse: instruction returned
if_rdata  output  DATA  fetched instruction
ls_req  input  1  load/store request; held high until dm_valid
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDRESS  data address
ls_wdata  input  DATA  store data
ls_be  input  DATA/8  byte enables
dm_valid  output  1  one-cycle pulse: load/store complete
dm_rdata  output  DATA  load data
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  ADDRESS  memory address
mem_wdata  output  DATA  memory write data
mem_be  output  DATA/8  memory byte enables
mem_rdata  input  DATA  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, one cycle
bus_err  output  1  one-cycle pulse: access aborted (timeout)

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0, including if_rdata and dm_rdata.
- Reset mid-access: mem_req drops immediately and the transaction is discarded. No valid pulse is issued afterwards.
- States: IDLE, IF_BUSY, LS_BUSY, RESP. All outputs are registered.
- IDLE:
  - ls_req=1 → LS_BUSY. Latch ls_addr, ls_we, ls_wdata, ls_be.
  - Else if_req=1 → IF_BUSY. Latch if_addr with bits [1:0] forced to 0; mem_we=0; mem_be all ones.
  - Both requests in the same cycle → LS wins. IF is granted after the LS response.
- IF_BUSY / LS_BUSY:
  - mem_req=1 with latched fields stable.
  - Wait for mem_ack; stall indefinitely unless the timeout is enabled.
  - On mem_ack → RESP:
    - IF: capture mem_rdata into if_rdata.
    - LS load: capture mem_rdata into dm_rdata.
    - LS store: dm_rdata unchanged.
  - mem_req, mem_we and mem_be clear in the same edge.
- RESP:
  - Exactly one of if_valid / dm_valid is high for one cycle → IDLE.
  - Requests are not sampled in RESP. This lets the requester drop req after seeing valid without a spurious re-grant.
- Latency: request seen in IDLE at cycle 0, mem_req at cycle 1. With zero-wait memory (ack at cycle 1), valid is at cycle 2.
- Throughput: one access per 3 cycles minimum.
- if_rdata / dm_rdata hold their last value until the next capture.
- Requests that drop before being granted are ignored. A request changing its fields while BUSY has no effect.
- mem_ack outside BUSY states is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter reset on entry to a BUSY state, incremented each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT-1 without ack: drop mem_req and go to RESP.
  - In RESP, pulse the matching valid together with bus_err=1. rdata is not updated.
  - Ack and timeout in the same cycle → the ack wins; bus_err=0.
- Not defined: no counter; bus_err tied 0; BUSY waits forever.

Test Plan:
- Reset: assert rst low mid-LS_BUSY with mem_req=1 → mem_req=0 at once; no dm_valid after release; all outputs 0.
- Fetch, zero-wait: if_req, if_addr=0x0000_0106, ack next cycle with rdata=0x0000_0093 → mem_addr=0x104, mem_we=0; if_valid at cycle 2 with if_rdata=0x93.
- Priority: if_req and ls_req (load 0x200) together → memory sees 0x200 first, dm_valid pulses; IF is granted in the following IDLE cycle.
- Store with wait states: ls_we=1, addr 0x40, wdata 0xDEADBEEF, be 0x3, ack after 5 cycles → mem_req high for 5 cycles with fields stable; dm_valid pulses once; dm_rdata unchanged.
- No re-grant: requester holds if_req through the RESP cycle and drops it the cycle after → exactly one memory access.
- ARB_TIMEOUT_EN, TIMEOUT=16, no ack → mem_req drops after 16 BUSY cycles; if_valid and bus_err pulse together; if_rdata unchanged.
